// File: rtl/game_pkg.sv
// Shared definitions for the game flow controller: panel geometry, RGB565
// colours, FSM state encoding and the ASK-screen cursor bands.
package game_pkg;

    localparam int SCREEN_W    = 96;
    localparam int SCREEN_H    = 64;
    localparam int PIXEL_COUNT = SCREEN_W * SCREEN_H;

    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] BLUE   = 16'h001F;
    localparam logic [15:0] YELLOW = 16'hFFE0;

    typedef enum logic [1:0] {
        GS_IDLE   = 2'd0,
        GS_ASK    = 2'd1,
        GS_RESULT = 2'd2
    } game_state_e;

    // Plain-vector aliases of the enum so older modules can keep a logic [1:0] register.
    localparam logic [1:0] ST_IDLE   = 2'(GS_IDLE);
    localparam logic [1:0] ST_ASK    = 2'(GS_ASK);
    localparam logic [1:0] ST_RESULT = 2'(GS_RESULT);

    localparam logic [6:0] CURSOR_X_LO  = 7'd18;
    localparam logic [6:0] CURSOR_X_HI  = 7'd20;
    localparam logic [5:0] CURSOR1_Y_LO = 6'd35;
    localparam logic [5:0] CURSOR1_Y_HI = 6'd39;
    localparam logic [5:0] CURSOR2_Y_LO = 6'd44;
    localparam logic [5:0] CURSOR2_Y_HI = 6'd48;

    function automatic logic in_cursor_band(input logic [6:0] px,
                                            input logic [5:0] py,
                                            input logic [1:0] cur);
        logic in_x;
        logic in_y1;
        logic in_y2;
        in_x  = (px >= CURSOR_X_LO) && (px <= CURSOR_X_HI);
        in_y1 = (py >= CURSOR1_Y_LO) && (py <= CURSOR1_Y_HI);
        in_y2 = (py >= CURSOR2_Y_LO) && (py <= CURSOR2_Y_HI);
        return in_x && (((cur == 2'd1) && in_y1) || ((cur == 2'd2) && in_y2));
    endfunction

endpackage

// File: rtl/game_flow_ctrl_btn_debounce.sv
// Button debouncer: a level is accepted only after it has held for
// DEBOUNCE_CYCLES consecutive clocks; an accepted rising level emits one pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt;
    logic          level;

    // cnt tracks how long btn has disagreed with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (btn == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= btn;
                rise  <= btn;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: IDLE -> ASK -> RESULT screen sequencing and pixel mux.
// Optional macro GAME_TIMEOUT_EN adds an ASK timeout that auto-confirms option 1.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4000,
    parameter int RESULT_FRAMES   = 60,
    parameter int TIMEOUT_FRAMES  = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_begin,
    input  logic [12:0] pixel_index,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_centre,
    input  logic [15:0] scr_data0,
    input  logic [15:0] scr_data1,
    input  logic [15:0] scr_data2,
    input  logic [15:0] scr_data3,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic [15:0] oled_data,
    output logic [1:0]  choice,
    output logic        choice_valid
);

`ifdef GAME_TIMEOUT_EN
    localparam int FRAME_MAX = (TIMEOUT_FRAMES > RESULT_FRAMES) ? TIMEOUT_FRAMES : RESULT_FRAMES;
`else
    localparam int FRAME_MAX = RESULT_FRAMES;
`endif
    localparam int              FCW       = $clog2(FRAME_MAX + 1);
    localparam logic [FCW-1:0]  FRAME_SAT = FCW'(FRAME_MAX);

    logic           up_ev;
    logic           down_ev;
    logic           centre_ev;
    logic [1:0]     state;
    logic [1:0]     cursor;
    logic [FCW-1:0] frame_cnt;
    logic           in_range;
    logic           pix_ok;
    logic [6:0]     pix_x;
    logic [5:0]     pix_y;
    logic [15:0]    screen_px;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst_n(rst_n), .btn(btn_up), .rise(up_ev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst_n(rst_n), .btn(btn_down), .rise(down_ev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_centre (
        .clk(clk), .rst_n(rst_n), .btn(btn_centre), .rise(centre_ev)
    );

    assign in_range = (pixel_index < 13'(PIXEL_COUNT));
    assign pix_x    = 7'(pixel_index % 13'(SCREEN_W));
    assign pix_y    = 6'(pixel_index / 13'(SCREEN_W));

    always_comb begin
        screen_px = scr_data0;
        case (state)
            ST_ASK:    screen_px = in_cursor_band(x, y, cursor) ? RED : scr_data1;
            ST_RESULT: screen_px = (choice == 2'd2) ? scr_data3 : scr_data2;
            default:   screen_px = scr_data0;
        endcase
    end

    // Two-stage pixel pipeline; pix_ok carries the off-panel flag alongside x/y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            pix_ok    <= 1'b0;
            oled_data <= BLACK;
        end else begin
            pix_ok    <= in_range;
            x         <= in_range ? pix_x : 7'd0;
            y         <= in_range ? pix_y : 6'd0;
            oled_data <= pix_ok ? screen_px : BLACK;
        end
    end

    // Centre is tested first in ASK so it confirms the cursor as it stood before any move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cursor       <= 2'd1;
            choice       <= 2'd0;
            choice_valid <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            choice_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (centre_ev) begin
                        state     <= ST_ASK;
                        cursor    <= 2'd1;
                        frame_cnt <= '0;
                    end
                end
                ST_ASK: begin
                    if (centre_ev) begin
                        choice       <= cursor;
                        choice_valid <= 1'b1;
                        state        <= ST_RESULT;
                        frame_cnt    <= '0;
                    end else begin
                        if (up_ev && !down_ev) begin
                            cursor <= 2'd1;
                        end else if (down_ev && !up_ev) begin
                            cursor <= 2'd2;
                        end
`ifdef GAME_TIMEOUT_EN
                        if (frame_begin) begin
                            if (frame_cnt == FCW'(TIMEOUT_FRAMES - 1)) begin
                                choice       <= 2'd1;
                                choice_valid <= 1'b1;
                                state        <= ST_RESULT;
                                frame_cnt    <= '0;
                            end else if (frame_cnt != FRAME_SAT) begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
`endif
                    end
                end
                ST_RESULT: begin
                    if (frame_begin) begin
                        if (frame_cnt == FCW'(RESULT_FRAMES - 1)) begin
                            state     <= ST_IDLE;
                            frame_cnt <= '0;
                        end else if (frame_cnt != FRAME_SAT) begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    frame_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: a screen-level behavioural model
// compared every cycle, plus directed literal checks.
module tb_game_flow_ctrl;

    localparam int DEB = 8;
    localparam int RF  = 60;
    localparam int TF  = 600;

    localparam logic [15:0] SCR0 = 16'h0A0A;
    localparam logic [15:0] SCR1 = 16'h1B1B;
    localparam logic [15:0] SCR2 = 16'h2C2C;
    localparam logic [15:0] SCR3 = 16'h3D3D;
    localparam logic [15:0] RED  = 16'hF800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_begin = 1'b0;
    logic [12:0] pixel_index = 13'd200;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_centre = 1'b0;
    logic [15:0] scr_data0 = SCR0;
    logic [15:0] scr_data1 = SCR1;
    logic [15:0] scr_data2 = SCR2;
    logic [15:0] scr_data3 = SCR3;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] oled_data;
    logic [1:0]  choice;
    logic        choice_valid;

    int n_checks = 0;
    int n_fail = 0;
    int valid_pulses = 0;

    game_flow_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .RESULT_FRAMES(RF),
        .TIMEOUT_FRAMES(TF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_begin(frame_begin),
        .pixel_index(pixel_index),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_centre(btn_centre),
        .scr_data0(scr_data0),
        .scr_data1(scr_data1),
        .scr_data2(scr_data2),
        .scr_data3(scr_data3),
        .x(x),
        .y(y),
        .oled_data(oled_data),
        .choice(choice),
        .choice_valid(choice_valid)
    );

    always #5 clk = ~clk;

    // Model state: screen 0=title, 1=question, 2=result.
    int          m_screen = 0;
    int          m_cursor = 1;
    int          m_frames = 0;
    logic [1:0]  m_choice = 2'd0;
    logic        m_valid = 1'b0;
    logic [6:0]  m_x = 7'd0;
    logic [5:0]  m_y = 6'd0;
    logic        m_inr = 1'b0;
    logic [15:0] m_oled = 16'h0000;
    int          run_len [3];
    logic        accepted [3];
    logic        pending [3];

    function automatic logic on_cursor(input logic [6:0] px, input logic [5:0] py, input int cur);
        return (px >= 18 && px <= 20) &&
               ((cur == 1 && py >= 35 && py <= 39) || (cur == 2 && py >= 44 && py <= 48));
    endfunction

    initial begin : behav_model
        logic ev [3];
        logic raw [3];
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_screen = 0; m_cursor = 1; m_frames = 0; m_choice = 2'd0; m_valid = 1'b0;
                m_x = 7'd0; m_y = 6'd0; m_inr = 1'b0; m_oled = 16'h0000;
                for (int b = 0; b < 3; b++) begin
                    run_len[b] = 0; accepted[b] = 1'b0; pending[b] = 1'b0;
                end
            end else begin
                if (!m_inr)             m_oled = 16'h0000;
                else if (m_screen == 0) m_oled = SCR0;
                else if (m_screen == 1) m_oled = on_cursor(m_x, m_y, m_cursor) ? RED : SCR1;
                else                    m_oled = (m_choice == 2'd2) ? SCR3 : SCR2;
                m_inr = (pixel_index < 13'd6144);
                m_x   = m_inr ? 7'(pixel_index % 96) : 7'd0;
                m_y   = m_inr ? 6'(pixel_index / 96) : 6'd0;

                raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_centre;
                for (int b = 0; b < 3; b++) begin
                    ev[b] = pending[b];
                    pending[b] = 1'b0;
                    if (raw[b] != accepted[b]) begin
                        run_len[b] = run_len[b] + 1;
                        if (run_len[b] == DEB) begin
                            accepted[b] = raw[b];
                            pending[b] = raw[b];
                            run_len[b] = 0;
                        end
                    end else begin
                        run_len[b] = 0;
                    end
                end

                m_valid = 1'b0;
                if (m_screen == 0) begin
                    if (ev[2]) begin m_screen = 1; m_cursor = 1; m_frames = 0; end
                end else if (m_screen == 1) begin
                    if (ev[2]) begin
                        m_choice = 2'(m_cursor); m_valid = 1'b1; m_screen = 2; m_frames = 0;
                    end else begin
                        if (ev[0] && !ev[1]) m_cursor = 1;
                        else if (ev[1] && !ev[0]) m_cursor = 2;
`ifdef GAME_TIMEOUT_EN
                        if (frame_begin) begin
                            m_frames = m_frames + 1;
                            if (m_frames == TF) begin
                                m_choice = 2'd1; m_valid = 1'b1; m_screen = 2; m_frames = 0;
                            end
                        end
`endif
                    end
                end else begin
                    if (frame_begin) begin
                        m_frames = m_frames + 1;
                        if (m_frames == RF) begin m_screen = 0; m_frames = 0; end
                    end
                end
            end
        end
    end

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            n_checks++;
            if ({x, y, oled_data, choice, choice_valid} !== {m_x, m_y, m_oled, m_choice, m_valid}) begin
                n_fail++;
                $display("[TB] FAIL cycle_compare t=%0t got x=%0d y=%0d oled=%h choice=%0d valid=%b, want x=%0d y=%0d oled=%h choice=%0d valid=%b",
                         $time, x, y, oled_data, choice, choice_valid, m_x, m_y, m_oled, m_choice, m_valid);
            end
        end
    end

    initial begin : pulse_counter
        forever begin
            @(negedge clk);
            if (choice_valid === 1'b1) valid_pulses++;
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "[TB] watchdog");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic up, input logic down, input logic centre, input int hold);
        btn_up = up; btn_down = down; btn_centre = centre;
        waitCycles(hold);
        btn_up = 1'b0; btn_down = 1'b0; btn_centre = 1'b0;
        waitCycles(DEB + 4);
    endtask

    task automatic pulseFrames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_begin = 1'b1;
            waitCycles(1);
            frame_begin = 1'b0;
            waitCycles(1);
        end
    endtask

    task automatic showPixel(input logic [12:0] idx);
        pixel_index = idx;
        waitCycles(2);
    endtask

    initial begin : main
        int snap;
        #1 rst_n = 1'b0;
        waitCycles(3);
        checkOutput("reset_x", 32'(x), 32'd0);
        checkOutput("reset_y", 32'(y), 32'd0);
        checkOutput("reset_oled", 32'(oled_data), 32'h0000);
        checkOutput("reset_choice", 32'(choice), 32'd0);
        checkOutput("reset_valid", 32'(choice_valid), 32'd0);

        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("xy_latency_x", 32'(x), 32'd8);
        checkOutput("xy_latency_y", 32'(y), 32'd2);
        waitCycles(1);
        checkOutput("oled_latency_idle", 32'(oled_data), 32'(SCR0));

        applyStimulus(1'b0, 1'b0, 1'b1, DEB - 1);
        checkOutput("short_centre_stays_idle", 32'(oled_data), 32'(SCR0));
        applyStimulus(1'b0, 1'b0, 1'b1, DEB);
        checkOutput("full_centre_enters_ask", 32'(oled_data), 32'(SCR1));
        showPixel(13'd3571);
        checkOutput("cursor1_overlay", 32'(oled_data), 32'(RED));

        applyStimulus(1'b0, 1'b1, 1'b0, DEB);
        showPixel(13'd4435);
        checkOutput("cursor2_overlay_19_46", 32'(oled_data), 32'(RED));
        showPixel(13'd3571);
        checkOutput("cursor1_band_cleared", 32'(oled_data), 32'(SCR1));

        applyStimulus(1'b1, 1'b1, 1'b0, DEB);
        showPixel(13'd4435);
        checkOutput("up_down_together_ignored", 32'(oled_data), 32'(RED));

        snap = valid_pulses;
        applyStimulus(1'b0, 1'b0, 1'b1, DEB);
        checkOutput("confirm_choice2", 32'(choice), 32'd2);
        checkOutput("confirm_one_pulse", 32'(valid_pulses - snap), 32'd1);
        checkOutput("result_shows_scr3", 32'(oled_data), 32'(SCR3));

        snap = valid_pulses;
        applyStimulus(1'b1, 1'b0, 1'b0, DEB);
        applyStimulus(1'b0, 1'b1, 1'b0, DEB);
        applyStimulus(1'b0, 1'b0, 1'b1, DEB);
        checkOutput("result_ignores_buttons", 32'(oled_data), 32'(SCR3));
        checkOutput("result_no_new_pulse", 32'(valid_pulses - snap), 32'd0);
        pulseFrames(RF - 1);
        checkOutput("result_held_59_frames", 32'(oled_data), 32'(SCR3));
        pulseFrames(1);
        waitCycles(1);
        checkOutput("idle_after_60th_frame", 32'(oled_data), 32'(SCR0));

        applyStimulus(1'b0, 1'b0, 1'b1, DEB);
        applyStimulus(1'b0, 1'b1, 1'b0, DEB);
        snap = valid_pulses;
        applyStimulus(1'b1, 1'b0, 1'b1, DEB);
        checkOutput("centre_beats_up_choice", 32'(choice), 32'd2);
        checkOutput("centre_beats_up_pulse", 32'(valid_pulses - snap), 32'd1);
        showPixel(13'd6144);
        checkOutput("offpanel_x", 32'(x), 32'd0);
        checkOutput("offpanel_y", 32'(y), 32'd0);
        checkOutput("offpanel_oled", 32'(oled_data), 32'h0000);
        showPixel(13'd6143);
        checkOutput("last_pixel_x", 32'(x), 32'd95);
        checkOutput("last_pixel_y", 32'(y), 32'd63);

        pixel_index = 13'd200;
        snap = valid_pulses;
        rst_n = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(3);
        checkOutput("reset_mid_result_idle", 32'(oled_data), 32'(SCR0));
        checkOutput("reset_mid_result_choice", 32'(choice), 32'd0);
        checkOutput("reset_mid_result_no_pulse", 32'(valid_pulses - snap), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b1, DEB);
        rst_n = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(3);
        checkOutput("reset_mid_ask_idle", 32'(oled_data), 32'(SCR0));
        checkOutput("reset_mid_ask_no_pulse", 32'(valid_pulses - snap), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b1, DEB);
        applyStimulus(1'b0, 1'b1, 1'b0, DEB);
        pulseFrames(TF - 1);
        checkOutput("ask_before_timeout", 32'(oled_data), 32'(SCR1));
        checkOutput("ask_before_timeout_pulse", 32'(valid_pulses - snap), 32'd0);
        pulseFrames(1);
        waitCycles(1);
`ifdef GAME_TIMEOUT_EN
        checkOutput("timeout_choice1", 32'(choice), 32'd1);
        checkOutput("timeout_pulse", 32'(valid_pulses - snap), 32'd1);
        checkOutput("timeout_result_scr2", 32'(oled_data), 32'(SCR2));
        pulseFrames(1000 - TF);
        checkOutput("after_1000_frames", 32'(oled_data), 32'(SCR0));
`else
        checkOutput("no_timeout_choice", 32'(choice), 32'd0);
        checkOutput("no_timeout_pulse", 32'(valid_pulses - snap), 32'd0);
        pulseFrames(1000 - TF);
        checkOutput("after_1000_frames", 32'(oled_data), 32'(SCR1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4000: number of stable clk cycles required before a button level is accepted.
REQ-002 Parameter RESULT_FRAMES, default 60: number of frames the result screen is held.
REQ-003 Parameter TIMEOUT_FRAMES, default 600: number of frames in ASK with no confirm before timeout.
REQ-004 Port clk, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port frame_begin, input, 1: one-cycle pulse at the start of each OLED frame.
REQ-007 Port pixel_index, input, 13: linear pixel address, 0..6143 on a 96x64 panel.
REQ-008 Ports btn_up, btn_down, btn_centre, input, 1 each: synchronised raw button levels.
REQ-009 Ports scr_data0..scr_data3, input, 16 each: RGB565 from the four screen renderers.
REQ-010 Ports x (7 bits) and y (6 bits), output: pixel coordinates driven to all renderers.
REQ-011 Port oled_data, output, 16: selected RGB565 pixel.
REQ-012 Port choice, output, 2: confirmed option, 1 or 2.
REQ-013 Port choice_valid, output, 1: one-cycle pulse on confirm.

Function
REQ-014 x and y SHALL be registered from pixel_index: x = index mod 96, y = index div 96, with 1-cycle latency.
REQ-015 oled_data SHALL be registered one cycle after x and y, giving 2 cycles total from pixel_index.
REQ-016 For pixel_index > 6143, x and y SHALL be 0 and oled_data SHALL be 0x0000.
REQ-017 Each button SHALL pass through a debouncer; only the rising edge of a debounced level SHALL act, as a single-cycle event.
REQ-018 FSM states: IDLE, ASK, RESULT.
REQ-019 IDLE: scr_data0 selected; centre event -> ASK, cursor set to 1.
REQ-020 ASK: scr_data1 selected; up event -> cursor 1; down event -> cursor 2; up and down in the same cycle SHALL be ignored.
REQ-021 ASK: centre event -> choice = cursor, choice_valid pulse, then -> RESULT.
  - Centre SHALL take priority over a simultaneous up or down, confirming the pre-move cursor.
REQ-022 ASK cursor overlay: pixels with x in 18..20 and y in 35..39 (cursor 1) or 44..48 (cursor 2) SHALL output 0xF800; all other pixels pass scr_data1.
REQ-023 RESULT: scr_data2 selected if choice = 1, scr_data3 if choice = 2.
  - Frame counter increments on frame_begin.
  - At RESULT_FRAMES, go to IDLE and clear the counter.
REQ-024 The frame counter SHALL clear on every state entry and SHALL saturate, never wrap.
REQ-025 Button events in RESULT SHALL be ignored.
REQ-026 choice SHALL hold its value until the next confirm.

Reset
REQ-027 On rst_n low, asynchronously: state IDLE, cursor 1, x = 0, y = 0, oled_data = 0x0000, choice = 0, choice_valid = 0, counters and debouncers cleared.
REQ-028 Reset mid-RESULT or mid-ASK SHALL return to IDLE with no choice_valid pulse.

Configuration
REQ-029 Macro GAME_TIMEOUT_EN defined: in ASK, TIMEOUT_FRAMES frame_begin pulses without a centre event SHALL force choice = 1, pulse choice_valid, and go to RESULT.
  - Up and down events do not reset the timeout count.
REQ-030 GAME_TIMEOUT_EN undefined: ASK SHALL wait indefinitely, and no timeout counter logic SHALL exist.

Structure
REQ-031 Shared package game_pkg SHALL hold:
  - the RGB565 colour constants (BLACK, WHITE, RED, ...)
  - SCREEN_W = 96, SCREEN_H = 64
  - the FSM state enum
  - the cursor band coordinates
REQ-032 One sub-module btn_debounce (parameter DEBOUNCE_CYCLES), instantiated three times.

Verification
REQ-033 Reset release, pixel_index = 200 -> x = 8, y = 2 after 1 cycle; oled_data = scr_data0 after 2 cycles.
REQ-034 Centre held for DEBOUNCE_CYCLES-1 cycles -> no transition; held for DEBOUNCE_CYCLES -> ASK.
REQ-035 ASK, down then centre -> choice = 2 with one choice_valid pulse; pixel (19,46) reads 0xF800 before confirm; scr_data3 shown in RESULT.
REQ-036 RESULT with RESULT_FRAMES = 60 -> IDLE after the 60th frame_begin; button presses during RESULT cause no change.
REQ-037 Up and centre in the same cycle with cursor 2 -> choice = 2; pixel_index 6144 -> oled_data 0x0000.
REQ-038 GAME_TIMEOUT_EN with TIMEOUT_FRAMES = 600, no input in ASK -> choice = 1 and choice_valid after the 600th frame_begin; without the macro, still in ASK after 1000 frames.
